// File: rtl/l1_conv_sched_pkg.sv
// Shared types and default geometry for the layer-1 readout scheduler.
// The default grid is 11x11 windows, starting at read address 0x1C.
package l1_pkg;

  localparam int          L1_AW       = 8;
  localparam int          L1_MAP_W    = 11;
  localparam int          L1_MAP_H    = 11;
  localparam int          L1_ROW_SKIP = 3;
  localparam logic [7:0]  L1_RD_BASE  = 8'h1C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ISSUE     = 3'd2,
    WAIT_MAC  = 3'd3,
    EMIT      = 3'd4,
    ADVANCE   = 3'd5,
    DONE      = 3'd6
  } l1_state_t;

endpackage

// File: rtl/l1_conv_sched_if.sv
// Control/handshake bundle between the scheduler and its surroundings.
// The slave modport is the scheduler side; the master modport is the environment side.
interface l1_conv_sched_if #(
  parameter int AW = 8
);
  logic          start;
  logic          abort;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          mac_start;
  logic          mac_done;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    col;
  logic [3:0]    row;
  logic          busy;
  logic          frame_done;

  modport master (
    output start, abort, wr_addr, mac_done, out_ready,
    input  rd_addr, mac_start, out_valid, col, row, busy, frame_done
  );

  modport slave (
    input  start, abort, wr_addr, mac_done, out_ready,
    output rd_addr, mac_start, out_valid, col, row, busy, frame_done
  );
endinterface

// File: rtl/l1_pos_cnt.sv
// Window position counter: column, row and the matching layer-1 read address.
// clr has priority over adv; advancing from the last position leaves everything unchanged.
module l1_pos_cnt #(
  parameter int          AW    = 8,
  parameter int          MAP_W = 11,
  parameter int          MAP_H = 11,
  parameter int          SKIP  = 3,
  parameter logic [AW-1:0] BASE = 8'h1C
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic          clr,
  output logic [AW-1:0] rd_addr,
  output logic [3:0]    col,
  output logic [3:0]    row,
  output logic          last_col,
  output logic          last_pos
);

  assign last_col = (col == 4'(MAP_W - 1));
  assign last_pos = last_col && (row == 4'(MAP_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= BASE;
      col     <= '0;
      row     <= '0;
    end else if (clr) begin
      rd_addr <= BASE;
      col     <= '0;
      row     <= '0;
    end else if (adv) begin
      if (!last_col) begin
        col     <= col + 4'd1;
        rd_addr <= rd_addr + AW'(1);
      end else if (!last_pos) begin
        // End of row: the skip replaces the normal +1 step.
        col     <= '0;
        row     <= row + 4'd1;
        rd_addr <= rd_addr + AW'(SKIP);
      end
    end
  end

endmodule

// File: rtl/l1_conv_sched.sv
// Layer-1 readout scheduler: walks the window grid, gates on the write pointer,
// launches the layer-2 MAC and holds each result until downstream takes it.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no frame in progress, waiting for start
// WAIT_DATA | waiting for the write pointer to pass rd_addr
// ISSUE     | mac_start pulse for the current window
// WAIT_MAC  | waiting for mac_done
// EMIT      | out_valid held until out_ready
// ADVANCE   | step to the next window, or finish on the last one
// DONE      | frame_done pulse, then counters return to BASE
module l1_conv_sched
  import l1_pkg::*;
#(
  parameter int            MAP_W = L1_MAP_W,
  parameter int            MAP_H = L1_MAP_H,
  parameter int            SKIP  = L1_ROW_SKIP,
  parameter int            AW    = L1_AW,
  parameter logic [AW-1:0] BASE  = L1_RD_BASE
) (
  input  logic             clk,
  input  logic             rst_n,
  l1_conv_sched_if.slave   bus
);

  l1_state_t     state, state_n;
  logic          adv, clr;
  logic          last_col, last_pos;
  logic [AW-1:0] rd_addr;
  logic [3:0]    col, row;
  logic          mac_start_q, out_valid_q, busy_q, frame_done_q;

  l1_pos_cnt #(
    .AW    (AW),
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .SKIP  (SKIP),
    .BASE  (BASE)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (adv),
    .clr      (clr),
    .rd_addr  (rd_addr),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_pos (last_pos)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    adv     = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE:      if (bus.start) state_n = WAIT_DATA;
      WAIT_DATA: if (rd_addr < bus.wr_addr) state_n = ISSUE;
      ISSUE:     state_n = WAIT_MAC;
      WAIT_MAC:  if (bus.mac_done) state_n = EMIT;
      EMIT:      if (bus.out_ready) state_n = ADVANCE;
      ADVANCE: begin
        adv     = 1'b1;
        state_n = last_pos ? DONE : WAIT_DATA;
      end
      DONE: begin
        clr     = 1'b1;
        state_n = IDLE;
      end
      default:   state_n = IDLE;
    endcase
    // Abort overrides everything, including a pending advance.
    if (bus.abort) begin
      state_n = IDLE;
      adv     = 1'b0;
      clr     = 1'b1;
    end
  end

  // Outputs are flopped from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mac_start_q  <= (state_n == ISSUE);
      out_valid_q  <= (state_n == EMIT);
      busy_q       <= (state_n != IDLE);
      frame_done_q <= (state_n == DONE);
    end
  end

  assign bus.rd_addr    = rd_addr;
  assign bus.col        = col;
  assign bus.row        = row;
  assign bus.mac_start  = mac_start_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_l1_conv_sched.sv
// Scoreboard bench for l1_conv_sched on a 3x2 grid: expected windows are queued
// by the stimulus and popped by a monitor on every mac_start / frame_done.
module tb_l1_conv_sched;
  import l1_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] c;
    logic [3:0] r;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mac_done_auto = 1'b0;
  logic mac_done_stray = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_mac = 0;
  int n_hs  = 0;
  int n_fd  = 0;

  win_t       exp_q[$];
  logic [7:0] fd_q[$];
  win_t       frame_tbl[6];

  l1_conv_sched_if #(.AW(8)) m();

  assign m.mac_done = mac_done_auto | mac_done_stray;

  l1_conv_sched #(
    .MAP_W (3),
    .MAP_H (2),
    .SKIP  (3),
    .AW    (8),
    .BASE  (8'h1C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int first, input int last, input bool_fd);
    for (int i = first; i <= last; i++) exp_q.push_back(frame_tbl[i]);
    if (bool_fd != 0) fd_q.push_back(8'h23);
  endtask

  task automatic wait_ov(input string nm);
    int t = 0;
    while (!m.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(nm, int'(m.out_valid), 1);
  endtask

  task automatic wait_fd(input int target, input string nm);
    int t = 0;
    while (n_fd < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, n_fd, target);
  endtask

  // MAC model: result two cycles after each launch.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m.mac_start) begin
        @(posedge clk);
        @(posedge clk);
        #1 mac_done_auto = 1'b1;
        @(posedge clk);
        #1 mac_done_auto = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    win_t       e;
    logic [7:0] fa;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m.mac_start) begin
          n_mac++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_mac_start: got addr 0x%0h col %0d row %0d, expected no launch",
                     m.rd_addr, m.col, m.row);
          end else begin
            e = exp_q.pop_front();
            if ({m.rd_addr, m.col, m.row} !== e) begin
              n_err++;
              $display("FAIL sb_window: got addr 0x%0h col %0d row %0d, expected addr 0x%0h col %0d row %0d",
                       m.rd_addr, m.col, m.row, e.a, e.c, e.r);
            end
          end
        end
        if (m.out_valid && m.out_ready) n_hs++;
        if (m.frame_done) begin
          n_fd++;
          n_cmp++;
          if (fd_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_frame_done: got pulse at addr 0x%0h, expected none", m.rd_addr);
          end else begin
            fa = fd_q.pop_front();
            if (m.rd_addr !== fa) begin
              n_err++;
              $display("FAIL sb_frame_done_addr: got 0x%0h, expected 0x%0h", m.rd_addr, fa);
            end
          end
        end
      end
    end
  end

  initial begin
    int m0, f0, h0, t;

    frame_tbl[0] = '{a: 8'h1C, c: 4'd0, r: 4'd0};
    frame_tbl[1] = '{a: 8'h1D, c: 4'd1, r: 4'd0};
    frame_tbl[2] = '{a: 8'h1E, c: 4'd2, r: 4'd0};
    frame_tbl[3] = '{a: 8'h21, c: 4'd0, r: 4'd1};
    frame_tbl[4] = '{a: 8'h22, c: 4'd1, r: 4'd1};
    frame_tbl[5] = '{a: 8'h23, c: 4'd2, r: 4'd1};

    m.start     = 1'b0;
    m.abort     = 1'b0;
    m.wr_addr   = 8'h00;
    m.out_ready = 1'b1;

    // Reset values
    tick(3);
    chk("rst_rd_addr", int'(m.rd_addr), 'h1C);
    chk("rst_busy", int'(m.busy), 0);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_col_row", int'({m.col, m.row}), 0);
    chk("post_rst_ctrl", int'({m.mac_start, m.out_valid, m.busy, m.frame_done}), 0);

    // Full frame with data present
    m.wr_addr = 8'hFF;
    push_frame(0, 5, 1);
    m0 = n_mac; h0 = n_hs; f0 = n_fd;
    m.start = 1'b1;
    tick(1);
    m.start = 1'b0;
    wait_fd(f0 + 1, "frame1_done");
    @(negedge clk);
    chk("frame1_mac_count", n_mac - m0, 6);
    chk("frame1_hs_count", n_hs - h0, 6);
    chk("frame1_idle", int'(m.busy), 0);
    chk("frame1_rd_base", int'(m.rd_addr), 'h1C);
    chk("frame1_sb_empty", exp_q.size() + fd_q.size(), 0);

    // Starvation then backpressure on the first window
    tick(1);
    m.wr_addr   = 8'h1C;
    m.out_ready = 1'b0;
    push_frame(0, 0, 0);
    m.start = 1'b1;
    tick(1);
    m.start = 1'b0;
    m0 = n_mac;
    tick(20);
    chk("starve_no_mac", n_mac - m0, 0);
    chk("starve_busy", int'(m.busy), 1);
    m.wr_addr = 8'h1D;
    @(negedge clk);
    chk("starve_mac_cyc1", int'(m.mac_start), 0);
    @(negedge clk);
    chk("starve_mac_cyc2", int'(m.mac_start), 1);
    wait_ov("bp_wait_ov");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(m.out_valid), 1);
      chk("bp_pos", int'({m.rd_addr, m.col, m.row}), int'({8'h1C, 4'd0, 4'd0}));
    end
    chk("bp_no_mac", n_mac - m0, 1);
    tick(1);
    m.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", int'(m.out_valid), 1);
    @(negedge clk);
    chk("bp_advance_ov", int'(m.out_valid), 0);
    chk("bp_advance_addr", int'(m.rd_addr), 'h1C);
    @(negedge clk);
    chk("bp_after_adv", int'({m.rd_addr, m.col, m.row}), int'({8'h1D, 4'd1, 4'd0}));

    // Abort in WAIT_MAC at col=1,row=1
    tick(1);
    push_frame(1, 4, 0);
    m.wr_addr = 8'hFF;
    t = 0;
    while (!(m.mac_start && m.col == 4'd1 && m.row == 4'd1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reach_pos", int'({m.mac_start, m.col, m.row}), int'({1'b1, 4'd1, 4'd1}));
    tick(1);
    m.abort = 1'b1;
    tick(1);
    m.abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(m.busy), 0);
    chk("abort_pos", int'({m.rd_addr, m.col, m.row}), int'({8'h1C, 4'd0, 4'd0}));
    chk("abort_ctrl", int'({m.mac_start, m.out_valid, m.frame_done}), 0);
    m0 = n_mac; f0 = n_fd;
    tick(6);
    chk("abort_no_fd", n_fd - f0, 0);
    chk("abort_no_mac", n_mac - m0, 0);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Restart after abort, with stray mac_done in WAIT_DATA and start in EMIT
    m.wr_addr   = 8'h1C;
    m.out_ready = 1'b0;
    push_frame(0, 5, 1);
    m0 = n_mac; f0 = n_fd;
    m.start = 1'b1;
    tick(1);
    m.start = 1'b0;
    tick(3);
    mac_done_stray = 1'b1;
    tick(1);
    mac_done_stray = 1'b0;
    tick(3);
    chk("stray_done_no_mac", n_mac - m0, 0);
    chk("stray_done_busy", int'(m.busy), 1);
    m.wr_addr = 8'hFF;
    wait_ov("stray_wait_ov");
    tick(1);
    m.start = 1'b1;
    tick(1);
    m.start = 1'b0;
    tick(2);
    chk("stray_start_ov", int'(m.out_valid), 1);
    chk("stray_start_no_mac", n_mac - m0, 1);
    chk("stray_start_addr", int'(m.rd_addr), 'h1C);
    m.out_ready = 1'b1;
    wait_fd(f0 + 1, "frame2_done");
    @(negedge clk);
    chk("frame2_mac_count", n_mac - m0, 6);
    chk("frame2_sb_empty", exp_q.size() + fd_q.size(), 0);

    // Asynchronous reset mid-frame
    tick(1);
    push_frame(0, 5, 1);
    m0 = n_mac;
    m.start = 1'b1;
    tick(1);
    m.start = 1'b0;
    t = 0;
    while (n_mac == m0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("arst_launch_seen", n_mac - m0, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pos", int'({m.rd_addr, m.col, m.row}), int'({8'h1C, 4'd0, 4'd0}));
    chk("arst_ctrl", int'({m.mac_start, m.out_valid, m.busy, m.frame_done}), 0);
    exp_q.delete();
    fd_q.delete();
    tick(2);
    rst_n = 1'b1;
    m0 = n_mac;
    tick(10);
    chk("arst_stays_idle", int'(m.busy), 0);
    chk("arst_no_mac", n_mac - m0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_conv_sched.md
Name: l1_conv_sched

Overview:
Scheduler that sequences readout of the layer-1 pooled-feature RAM into the layer-2 convolution MAC engine.
- Walks a MAP_W x MAP_H grid of window positions and produces the RAM read address for each one.
- Waits for the write pointer to pass the read address, launches the MAC, holds each result until downstream accepts it, then advances.
- Sits between layer_1 storage and the layer-2 datapath. It is the only block that advances the layer-1 read address.

Parameters:
MAP_W, 11, window positions per row
MAP_H, 11, rows per frame
SKIP, 3, address increment applied at end of row instead of +1
BASE, 8'h1C, read address of the first window position
AW, 8, address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  frame start pulse
abort  in  1  frame abort / transmit-done clear
wr_addr  in  AW  current layer-1 write pointer
rd_addr  out  AW  layer-1 read address for the current window
mac_start  out  1  one-cycle launch pulse to the MAC engine
mac_done  in  1  MAC result ready pulse
out_valid  out  1  result available to downstream
out_ready  in  1  downstream accepts the result
col  out  4  current column index
row  out  4  current row index
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last window is accepted

Behaviour:
- Reset values: rd_addr=BASE; col=0; row=0; mac_start=0; out_valid=0; busy=0; frame_done=0; state=IDLE.
- State register and all outputs are registered.
- IDLE: start=1 -> WAIT_DATA. No other input has any effect in IDLE.
- WAIT_DATA: when rd_addr < wr_addr (unsigned) -> ISSUE; otherwise stay.
- ISSUE: mac_start=1 for exactly one cycle -> WAIT_MAC.
- WAIT_MAC: mac_done=1 -> EMIT. mac_done pulses in any other state are ignored.
- EMIT: out_valid=1, held stable until out_ready=1. The handshake completes on the cycle where out_valid and out_ready are both 1 -> ADVANCE.
- ADVANCE (one cycle):
  - col < MAP_W-1: col+1; rd_addr+1.
  - col = MAP_W-1 and row < MAP_H-1: col=0; row+1; rd_addr+SKIP.
  - col = MAP_W-1 and row = MAP_H-1 -> DONE; counters and rd_addr unchanged.
  - Otherwise -> WAIT_DATA.
- DONE: frame_done=1 for one cycle; then rd_addr=BASE, col=0, row=0 -> IDLE.
- Address arithmetic wraps modulo 2^AW, with no saturation.
- Minimum per-window latency with data present: WAIT_DATA 1, ISSUE 1, WAIT_MAC >=1, EMIT >=1, ADVANCE 1 cycle.
- abort is synchronous and has priority over every other input in every state. Next state is IDLE, rd_addr=BASE, col=row=0, all pulses and out_valid are cleared, and frame_done is not asserted.
- start while busy=1 is ignored. abort and start in the same cycle: abort wins, and start is dropped.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). After release the block waits in IDLE for a new start.

Decomposition:
- Package l1_pkg holds:
  - the state enum: IDLE, WAIT_DATA, ISSUE, WAIT_MAC, EMIT, ADVANCE, DONE;
  - L1_RD_BASE = 8'h1C;
  - L1_MAP_W = 11, L1_MAP_H = 11, L1_ROW_SKIP = 3.
- Sub-module l1_pos_cnt: col/row/rd_addr counter with inputs adv, clr and outputs last_col, last_pos. The FSM drives adv in ADVANCE and clr in DONE/abort.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> rd_addr=0x1C, col=row=0, all control outputs 0 without waiting for a clock edge.
2. Full frame: MAP_W=3, MAP_H=2, wr_addr=0xFF, mac_done 2 cycles after each mac_start, out_ready=1 -> rd_addr sequence 1C,1D,1E,21,22,23; exactly 6 mac_start and 6 out_valid handshakes; one frame_done; then IDLE with rd_addr=0x1C.
3. Starvation: wr_addr held at 0x1C after start -> no mac_start for 20 cycles. Set wr_addr=0x1D -> mac_start asserts on the 2nd cycle after the change.
4. Backpressure: out_ready=0 for 5 cycles in EMIT -> out_valid stays 1, rd_addr/col/row unchanged, no further mac_start. out_ready=1 -> ADVANCE on the next cycle.
5. Abort: abort=1 in WAIT_MAC at col=1,row=1 -> next cycle IDLE, rd_addr=0x1C, busy=0, no frame_done. A later start reissues from 0x1C.
6. Stray inputs: mac_done pulse in WAIT_DATA and start pulse in EMIT -> no state change and no extra mac_start.
